// File: rtl/ram_arb_pkg.sv
// Shared definitions for the work-RAM arbiter: default widths, grant
// encoding and FSM state encoding.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 16;

    // Grant / last-grant encoding; also the bit index into the request vector
    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_CAP  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. A lone request always wins; on a tie the
// requester that was not granted last wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,   // {dma, cpu}
    input  logic       last,  // previous grant
    output logic       grant
);

    // Pick the winner for this cycle
    always_comb begin
        grant = GRANT_CPU;
        if (req == 2'b11)
            grant = ~last;
        else if (req[1])
            grant = GRANT_DMA;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Work-RAM arbiter between the 68k CPU bus and the display DMA reader.
// Every access is IDLE -> ACC (address on RAM) -> CAP (data back), and CPU
// accesses then sit in HOLD with DTACK asserted until the bus cycle ends.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [1:0]        cpu_mask,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_dtack_n,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_valid,
    output logic              ram_we,
    output logic [1:0]        ram_mask,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    state_t            state_q;
    logic              gnt_q;       // owner of the access in flight
    logic              last_q;      // round-robin history
    logic              rw_q;        // 1 = access in flight is a read
    logic              ram_we_q;
    logic [1:0]        ram_mask_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;
    logic              dma_ack_q;
    logic              dma_valid_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              dtack_n_q;
    logic              grant_d;

    rr_arb2 u_rr (
        .req   ({dma_req, cpu_req}),
        .last  (last_q),
        .grant (grant_d)
    );

    // Access sequencer; all outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= GRANT_CPU;
            last_q      <= GRANT_DMA;
            rw_q        <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_mask_q  <= 2'b00;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            dma_ack_q   <= 1'b0;
            dma_valid_q <= 1'b0;
            dma_rdata_q <= '0;
            cpu_rdata_q <= '0;
            dtack_n_q   <= 1'b1;
        end else begin
            // single-cycle strobes default low
            ram_we_q    <= 1'b0;
            dma_ack_q   <= 1'b0;
            dma_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req || dma_req) begin
                        state_q <= S_ACC;
                        gnt_q   <= grant_d;
                        last_q  <= grant_d;
                        if (grant_d == GRANT_DMA) begin
                            // display fetch is always a full-word read
                            ram_addr_q <= dma_addr;
                            ram_mask_q <= 2'b11;
                            ram_din_q  <= '0;
                            rw_q       <= 1'b1;
                            dma_ack_q  <= 1'b1;
                        end else begin
                            ram_addr_q <= cpu_addr;
                            ram_mask_q <= cpu_mask;
                            ram_din_q  <= cpu_wdata;
                            rw_q       <= cpu_rw;
                            ram_we_q   <= ~cpu_rw;
                        end
                    end
                end
                S_ACC: state_q <= S_CAP;
                S_CAP: begin
                    if (gnt_q == GRANT_DMA) begin
                        dma_rdata_q <= ram_dout;
                        dma_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        if (rw_q)
                            cpu_rdata_q <= ram_dout;
                        // a bus cycle that already ended gets no DTACK
                        if (cpu_req) begin
                            dtack_n_q <= 1'b0;
                            state_q   <= S_HOLD;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_HOLD: begin
                    // keep DTACK until the 68k ends its bus cycle
                    if (!cpu_req) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_dtack_n = dtack_n_q;
    assign dma_ack     = dma_ack_q;
    assign dma_rdata   = dma_rdata_q;
    assign dma_valid   = dma_valid_q;
    assign ram_we      = ram_we_q;
    assign ram_mask    = ram_mask_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural work RAM and
// scoreboards for CPU DTACK data and DMA valid data.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_rw;
    logic [1:0]  cpu_mask;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_dtack_n;
    logic        dma_req;
    logic [10:0] dma_addr;
    logic        dma_ack, dma_valid;
    logic [15:0] dma_rdata;
    logic        ram_we;
    logic [1:0]  ram_mask;
    logic [10:0] ram_addr;
    logic [15:0] ram_din, ram_dout;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] cpu_q[$];
    logic [15:0] dma_q[$];
    logic        glog[$];
    logic        prev_dtack_n = 1'b1;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_mask(cpu_mask),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_dtack_n(cpu_dtack_n),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .dma_valid(dma_valid),
        .ram_we(ram_we), .ram_mask(ram_mask), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Work RAM: byte-masked write, one-cycle read latency, preset on reset
    logic [15:0] mem [0:2047];
    always @(posedge clk) begin
        if (rst) begin
            mem[11'h010] <= 16'hBEEF;
            mem[11'h020] <= 16'h00CD;
            mem[11'h040] <= 16'h4444;
            mem[11'h100] <= 16'h1111;
            mem[11'h200] <= 16'h2222;
            mem[11'h300] <= 16'h3333;
            mem[11'h7FF] <= 16'hA5A5;
        end else if (ram_we) begin
            if (ram_mask[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            if (ram_mask[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: DMA data on dma_valid, CPU data on DTACK falling edge
    always @(negedge clk) begin : mon
        logic [15:0] e;
        if (dma_valid) begin
            compared++;
            assert (dma_q.size() != 0) else begin
                mismatched++;
                $error("FAIL dma_valid_unexpected: observed data %0h expected no pulse", dma_rdata);
            end
            if (dma_q.size() != 0) begin
                e = dma_q.pop_front();
                compared++;
                assert (dma_rdata === e) else begin
                    mismatched++;
                    $error("FAIL dma_rdata: observed %0h expected %0h", dma_rdata, e);
                end
            end
        end
        if (prev_dtack_n === 1'b1 && cpu_dtack_n === 1'b0) begin
            compared++;
            assert (cpu_q.size() != 0) else begin
                mismatched++;
                $error("FAIL dtack_unexpected: observed dtack with data %0h expected none", cpu_rdata);
            end
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                compared++;
                assert (cpu_rdata === e) else begin
                    mismatched++;
                    $error("FAIL cpu_rdata: observed %0h expected %0h", cpu_rdata, e);
                end
            end
        end
        prev_dtack_n = cpu_dtack_n;
    end

    // Full 68k bus cycle: hold request until DTACK, then release
    task automatic cpu_cycle(input logic [10:0] a, input logic rw, input logic [1:0] m,
                             input logic [15:0] wd, input logic [15:0] exp);
        int n;
        cpu_addr = a; cpu_rw = rw; cpu_mask = m; cpu_wdata = wd; cpu_req = 1'b1;
        cpu_q.push_back(exp);
        n = 0;
        do begin step(); n++; end while (cpu_dtack_n !== 1'b0 && n < 20);
        chk("cpu_cycle_dtack", cpu_dtack_n, 1'b0);
        cpu_req = 1'b0;
        step();
        chk("cpu_cycle_release", cpu_dtack_n, 1'b1);
    endtask

    initial begin
        int n, cpu_n, dma_n;
        rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_mask = 2'b11;
        cpu_addr = '0; cpu_wdata = '0; dma_req = 1'b0; dma_addr = '0;
        repeat (3) step();
        chk("rst_dtack_n", cpu_dtack_n, 1'b1);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_dma_ack", dma_ack, 1'b0);
        chk("rst_dma_valid", dma_valid, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0);
        chk("rst_dma_rdata", dma_rdata, 16'h0);
        chk("rst_state", dut.state_q, S_IDLE);
        rst = 1'b0;
        step();

        // CPU read of 0x010
        cpu_addr = 11'h010; cpu_rw = 1'b1; cpu_mask = 2'b11; cpu_req = 1'b1;
        cpu_q.push_back(16'hBEEF);
        step();
        chk("rd_acc_addr", ram_addr, 11'h010);
        chk("rd_acc_we", ram_we, 1'b0);
        step();
        chk("rd_cap_dtack", cpu_dtack_n, 1'b1);
        step();
        chk("rd_n3_dtack", cpu_dtack_n, 1'b0);
        chk("rd_n3_data", cpu_rdata, 16'hBEEF);
        step();
        chk("rd_hold_dtack", cpu_dtack_n, 1'b0);
        cpu_req = 1'b0;
        step();
        chk("rd_release_dtack", cpu_dtack_n, 1'b1);
        chk("rd_release_state", dut.state_q, S_IDLE);

        // CPU upper-byte write, then read back
        cpu_addr = 11'h020; cpu_rw = 1'b0; cpu_mask = 2'b10; cpu_wdata = 16'h1234; cpu_req = 1'b1;
        cpu_q.push_back(16'hBEEF);
        step();
        chk("wr_acc_we", ram_we, 1'b1);
        chk("wr_acc_mask", ram_mask, 2'b10);
        chk("wr_acc_addr", ram_addr, 11'h020);
        chk("wr_acc_din", ram_din, 16'h1234);
        step();
        chk("wr_cap_we", ram_we, 1'b0);
        step();
        chk("wr_n3_dtack", cpu_dtack_n, 1'b0);
        cpu_req = 1'b0;
        step();
        chk("wr_release_dtack", cpu_dtack_n, 1'b1);
        cpu_cycle(11'h020, 1'b1, 2'b11, 16'h0, 16'h12CD);
        chk("wr_readback_upper", cpu_rdata[15:8], 8'h12);

        // DMA read at top address
        dma_addr = 11'h7FF; dma_req = 1'b1;
        dma_q.push_back(16'hA5A5);
        step();
        chk("dma_ack", dma_ack, 1'b1);
        chk("dma_acc_addr", ram_addr, 11'h7FF);
        chk("dma_acc_mask", ram_mask, 2'b11);
        chk("dma_acc_we", ram_we, 1'b0);
        dma_req = 1'b0;
        step();
        chk("dma_ack_pulse", dma_ack, 1'b0);
        chk("dma_valid_early", dma_valid, 1'b0);
        step();
        chk("dma_valid_n3", dma_valid, 1'b1);
        chk("dma_no_dtack", cpu_dtack_n, 1'b1);
        step();
        chk("dma_valid_pulse", dma_valid, 1'b0);

        // Simultaneous requests after reset: CPU first, then alternating
        rst = 1'b1; repeat (2) step(); rst = 1'b0;
        cpu_addr = 11'h100; cpu_rw = 1'b1; cpu_mask = 2'b11; dma_addr = 11'h200;
        cpu_req = 1'b1; dma_req = 1'b1;
        cpu_q.push_back(16'h1111); dma_q.push_back(16'h2222);
        cpu_n = 0; dma_n = 0; n = 0;
        while ((cpu_n < 3 || dma_n < 3) && n < 200) begin
            step(); n++;
            if (cpu_req && cpu_dtack_n === 1'b0) begin
                cpu_req = 1'b0; cpu_n++; glog.push_back(GRANT_CPU);
            end else if (!cpu_req && cpu_n < 3 && cpu_dtack_n === 1'b1) begin
                cpu_req = 1'b1; cpu_q.push_back(16'h1111);
            end
            if (dma_req && dma_ack === 1'b1) begin
                dma_n++; glog.push_back(GRANT_DMA);
                if (dma_n < 3) dma_q.push_back(16'h2222);
                else dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (4) step();
        chk("rr_grant_count", glog.size(), 6);
        for (int i = 0; i < glog.size(); i++)
            chk($sformatf("rr_grant_%0d", i), glog[i], (i % 2 == 0) ? GRANT_CPU : GRANT_DMA);

        // Reset during DMA ACC aborts the access
        dma_addr = 11'h300; dma_req = 1'b1;
        step();
        chk("abort_acc_ack", dma_ack, 1'b1);
        rst = 1'b1; dma_req = 1'b0;
        step();
        chk("abort_valid", dma_valid, 1'b0);
        chk("abort_we", ram_we, 1'b0);
        chk("abort_state", dut.state_q, S_IDLE);
        chk("abort_dtack", cpu_dtack_n, 1'b1);
        rst = 1'b0;
        repeat (2) step();
        chk("abort_no_late_valid", dma_valid, 1'b0);
        cpu_cycle(11'h010, 1'b1, 2'b11, 16'h0, 16'hBEEF);

        // One-cycle CPU pulse: access completes, no DTACK
        cpu_addr = 11'h040; cpu_rw = 1'b1; cpu_req = 1'b1;
        step();
        cpu_req = 1'b0;
        chk("pulse_acc_addr", ram_addr, 11'h040);
        step();
        chk("pulse_cap_dtack", cpu_dtack_n, 1'b1);
        step();
        chk("pulse_n3_state", dut.state_q, S_IDLE);
        chk("pulse_n3_dtack", cpu_dtack_n, 1'b1);
        chk("pulse_n3_data", cpu_rdata, 16'h4444);
        step();
        chk("pulse_after_dtack", cpu_dtack_n, 1'b1);

        // DMA waits out CPU HOLD, then wins the tie against a CPU re-request
        cpu_addr = 11'h010; cpu_rw = 1'b1; cpu_req = 1'b1;
        cpu_q.push_back(16'hBEEF);
        n = 0;
        do begin step(); n++; end while (cpu_dtack_n !== 1'b0 && n < 20);
        chk("hold_reached", cpu_dtack_n, 1'b0);
        dma_addr = 11'h200; dma_req = 1'b1;
        dma_q.push_back(16'h2222);
        repeat (2) begin
            step();
            chk("hold_dma_waits", dma_ack, 1'b0);
            chk("hold_dtack", cpu_dtack_n, 1'b0);
        end
        cpu_req = 1'b0;
        step();
        chk("hold_exit_dtack", cpu_dtack_n, 1'b1);
        cpu_req = 1'b1;
        cpu_q.push_back(16'hBEEF);
        step();
        chk("hold_dma_wins", dma_ack, 1'b1);
        dma_req = 1'b0;
        n = 0;
        do begin step(); n++; end while (cpu_dtack_n !== 1'b0 && n < 20);
        chk("hold_cpu_served", cpu_dtack_n, 1'b0);
        cpu_req = 1'b0;
        repeat (3) step();

        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("dma_q_empty", dma_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
